regbus_arb: RTL and testbench

REGBUS_ARB -- requirements
Module: regbus_arb

---
 rtl/regbus_arb.sv | 171 +++++++++++++++++
 tb/tb_regbus_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_arb.sv
`default_nettype none

// ============================================================================
//  Module      : regbus_arb
//  Description : Two-requester arbiter for a shared IP register bus.
//                Each transaction runs IDLE -> ACCESS -> RESP -> IDLE:
//                  - IDLE   : pick a winner and latch its request
//                  - ACCESS : drive the IP bus for exactly one cycle
//                  - RESP   : pulse the winner's done for one cycle
//                All outputs are registered.
//  Options     : REGBUS_ARB_RR_EN -- when defined, ties are resolved
//                round robin; otherwise requester 0 always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif

`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module regbus_arb #(
  parameter int ADDR_W = `AHB_ADDR_WIDTH,
  parameter int DATA_W = `AHB_DATA_WIDTH
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // requester 0
  input  logic              req0,
  input  logic              wr1_rd0_0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  // requester 1
  input  logic              req1,
  input  logic              wr1_rd0_1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  // status
  output logic              busy,
  // shared IP register bus
  output logic [ADDR_W-1:0] ip_addr,
  output logic [DATA_W-1:0] ip_write_data,
  output logic              ip_wr1_rd0,
  output logic              valid_reg_access,
  input  logic [DATA_W-1:0] ip_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_gnt;          // index of the requester owning the transaction

  logic              w_any_req;
  logic              w_tie;
  logic              w_win;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_wr;
  logic [DATA_W-1:0] w_capture;

  assign w_any_req = req0 | req1;
  assign w_tie     = req0 & req1;

`ifdef REGBUS_ARB_RR_EN
  // Requester granted most recently; reset to 1 so requester 0 wins the first tie
  logic r_last_gnt;

  // On a tie the requester not granted last wins; a lone request always wins
  assign w_win = w_tie ? ~r_last_gnt : (req1 & ~req0);

  // Round-robin pointer follows every grant made in IDLE
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_gnt <= 1'b1;
    end else if ((r_state == ST_IDLE) && w_any_req) begin
      r_last_gnt <= w_win;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is not asking
  assign w_win = req1 & ~req0 & ~w_tie;
`endif

  // Request fields of the current winner, latched on the grant edge
  assign w_win_addr  = w_win ? addr1     : addr0;
  assign w_win_wdata = w_win ? wdata1    : wdata0;
  assign w_win_wr    = w_win ? wr1_rd0_1 : wr1_rd0_0;

  // Writes return zero to the requester instead of whatever the IP drives
  assign w_capture = ip_wr1_rd0 ? '0 : ip_read_data;

  // Transaction sequencer with registered bus drive, done pulses and read data
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state          <= ST_IDLE;
      r_gnt            <= 1'b0;
      busy             <= 1'b0;
      done0            <= 1'b0;
      done1            <= 1'b0;
      rdata0           <= '0;
      rdata1           <= '0;
      ip_addr          <= '0;
      ip_write_data    <= '0;
      ip_wr1_rd0       <= 1'b0;
      valid_reg_access <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (w_any_req) begin
            r_state          <= ST_ACCESS;
            r_gnt            <= w_win;
            busy             <= 1'b1;
            valid_reg_access <= 1'b1;
            ip_addr          <= w_win_addr;
            ip_write_data    <= w_win_wdata;
            ip_wr1_rd0       <= w_win_wr;
          end
        end

        ST_ACCESS: begin
          // The IP bus is released as the read data is captured
          r_state          <= ST_RESP;
          valid_reg_access <= 1'b0;
          ip_addr          <= '0;
          ip_write_data    <= '0;
          ip_wr1_rd0       <= 1'b0;
          if (r_gnt) begin
            rdata1 <= w_capture;
            done1  <= 1'b1;
          end else begin
            rdata0 <= w_capture;
            done0  <= 1'b1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done0   <= 1'b0;
          done1   <= 1'b0;
        end

        default: begin
          r_state          <= ST_IDLE;
          busy             <= 1'b0;
          done0            <= 1'b0;
          done1            <= 1'b0;
          valid_reg_access <= 1'b0;
          ip_addr          <= '0;
          ip_write_data    <= '0;
          ip_wr1_rd0       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regbus_arb.sv
`default_nettype none

// ============================================================================
//  Module      : tb_regbus_arb
//  Description : Self-checking bench for regbus_arb. Stimulus pushes the
//                expected IP-bus accesses and done responses into queues; a
//                monitor pops and compares whenever the DUT presents them.
//                Expectations for the tie scenario follow REGBUS_ARB_RR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_regbus_arb;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        wr1_rd0_0 = 1'b0, wr1_rd0_1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] ip_read_data = '0;
  logic        done0, done1, busy, ip_wr1_rd0, valid_reg_access;
  logic [31:0] rdata0, rdata1, ip_addr, ip_write_data;

  regbus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .req0             (req0),
    .wr1_rd0_0        (wr1_rd0_0),
    .addr0            (addr0),
    .wdata0           (wdata0),
    .done0            (done0),
    .rdata0           (rdata0),
    .req1             (req1),
    .wr1_rd0_1        (wr1_rd0_1),
    .addr1            (addr1),
    .wdata1           (wdata1),
    .done1            (done1),
    .rdata1           (rdata1),
    .busy             (busy),
    .ip_addr          (ip_addr),
    .ip_write_data    (ip_write_data),
    .ip_wr1_rd0       (ip_wr1_rd0),
    .valid_reg_access (valid_reg_access),
    .ip_read_data     (ip_read_data)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } acc_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic [31:0] a, input logic [31:0] w, input logic wr);
    acc_t e;
    e.addr = a; e.wdata = w; e.wr = wr;
    acc_q.push_back(e);
  endtask

  task automatic push_rsp(input logic id, input logic [31:0] d);
    rsp_t e;
    e.id = id; e.data = d;
    rsp_q.push_back(e);
  endtask

  // Wait (bounded) for any done pulse; n = negedges sampled until it was seen.
  // Returns just after the edge on which the requester samples done.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!(done0 || done1) && n < 20);
    if (!(done0 || done1)) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=none required=done within 20 cycles");
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done0"}, 32'(done0), 32'd0);
    chk({tag, "_done1"}, 32'(done1), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(valid_reg_access), 32'd0);
    chk({tag, "_ip_addr"}, ip_addr, 32'd0);
    chk({tag, "_ip_wdata"}, ip_write_data, 32'd0);
    chk({tag, "_ip_wr"}, 32'(ip_wr1_rd0), 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
  endtask

  // Monitor: compare bus accesses and done responses against the queues
  initial begin
    logic prev_valid;
    acc_t a;
    rsp_t r;
    prev_valid = 1'b0;
    forever begin
      @(negedge HCLK);
      if (valid_reg_access) begin
        chk("access_one_cycle", 32'(prev_valid), 32'd0);
        if (acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_access actual=addr %h required=no access", ip_addr);
        end else begin
          a = acc_q.pop_front();
          chk("ip_addr", ip_addr, a.addr);
          chk("ip_write_data", ip_write_data, a.wdata);
          chk("ip_wr1_rd0", 32'(ip_wr1_rd0), 32'(a.wr));
        end
      end else begin
        chk("ip_bus_idle", ip_addr | ip_write_data | 32'(ip_wr1_rd0), 32'd0);
      end
      prev_valid = valid_reg_access;
      if (done0 || done1) begin
        chk("done_exclusive", 32'(done0 & done1), 32'd0);
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=done0 %0d done1 %0d required=no done", done0, done1);
        end else begin
          r = rsp_q.pop_front();
          chk("done_id", 32'(done1), 32'(r.id));
          chk("rdata", r.id ? rdata1 : rdata0, r.data);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    chk_all_zero("reset");
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Requester 0 read of 0x010
    req0 = 1'b1; wr1_rd0_0 = 1'b0; addr0 = 32'h010; wdata0 = '0;
    ip_read_data = 32'hA5A5_0001;
    push_acc(32'h010, 32'h0, 1'b0);
    push_rsp(1'b0, 32'hA5A5_0001);
    wait_done(n);
    req0 = 1'b0;
    chk("read_latency", 32'(n), 32'd3);

    // Requester 1 write of 0x148; IP read data must not leak into rdata1
    req1 = 1'b1; wr1_rd0_1 = 1'b1; addr1 = 32'h148; wdata1 = 32'h1234_5678;
    ip_read_data = 32'hDEAD_BEEF;
    push_acc(32'h148, 32'h1234_5678, 1'b1);
    push_rsp(1'b1, 32'h0);
    wait_done(n);
    req1 = 1'b0;
    chk("write_latency", 32'(n), 32'd3);
    chk("rdata0_hold", rdata0, 32'hA5A5_0001);

    // Both requesters held: 0 reads 0x100, 1 writes 0x104
    req0 = 1'b1; wr1_rd0_0 = 1'b0; addr0 = 32'h100; wdata0 = '0;
    req1 = 1'b1; wr1_rd0_1 = 1'b1; addr1 = 32'h104; wdata1 = 32'h0BAD_F00D;
    ip_read_data = 32'hCAFE_0003;
`ifdef REGBUS_ARB_RR_EN
    for (int k = 0; k < 2; k++) begin
      push_acc(32'h100, 32'h0, 1'b0);
      push_rsp(1'b0, 32'hCAFE_0003);
      push_acc(32'h104, 32'h0BAD_F00D, 1'b1);
      push_rsp(1'b1, 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      chk("tie_period", 32'(n), 32'd3);
    end
    req0 = 1'b0;
    req1 = 1'b0;
`else
    push_acc(32'h100, 32'h0, 1'b0);
    push_rsp(1'b0, 32'hCAFE_0003);
    push_acc(32'h100, 32'h0, 1'b0);
    push_rsp(1'b0, 32'hCAFE_0003);
    push_acc(32'h104, 32'h0BAD_F00D, 1'b1);
    push_rsp(1'b1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      wait_done(n);
      chk("tie_period", 32'(n), 32'd3);
    end
    req0 = 1'b0;
    wait_done(n);
    chk("loser_period", 32'(n), 32'd3);
    req1 = 1'b0;
`endif

    // Requester 1 read of 0x020; address changes to 0x030 during ACCESS
    req1 = 1'b1; wr1_rd0_1 = 1'b0; addr1 = 32'h020; wdata1 = '0;
    ip_read_data = 32'h0000_0BEE;
    push_acc(32'h020, 32'h0, 1'b0);
    push_rsp(1'b1, 32'h0000_0BEE);
    @(posedge HCLK);
    #1;
    addr1 = 32'h030;
    wait_done(n);
    req1 = 1'b0;

    // Reset asserted in RESP: everything clears at once, no done pulse
    req0 = 1'b1; wr1_rd0_0 = 1'b0; addr0 = 32'h088;
    ip_read_data = 32'h7777_0005;
    push_acc(32'h088, 32'h0, 1'b0);
    repeat (2) @(posedge HCLK);
    #1;
    chk("pre_reset_done0", 32'(done0), 32'd1);
    HRESETn = 1'b0;
    req0 = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Fresh read after reset completes normally
    req0 = 1'b1; wr1_rd0_0 = 1'b0; addr0 = 32'h044;
    ip_read_data = 32'h5555_AAAA;
    push_acc(32'h044, 32'h0, 1'b0);
    push_rsp(1'b0, 32'h5555_AAAA);
    wait_done(n);
    req0 = 1'b0;
    chk("post_reset_latency", 32'(n), 32'd3);

    repeat (3) @(posedge HCLK);
    #1;
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
